// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    // Port identifiers, used both as the winner id and as the last-grant pointer.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_IO  = 1'b1;

    // Every access is IDLE -> ACCESS -> COMPLETE -> IDLE.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner selection between the CPU and I/O requests.
// Optional feature macro: MEM_ARB_RR_EN (round-robin on ties). Without it the
// CPU always wins a tie and the last-grant input has no effect.
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic io_req,
    input  logic last_grant,
    output logic grant
);

`ifdef MEM_ARB_RR_EN
    // On a tie the port that was not granted last time wins.
    always_comb begin
        grant = PORT_CPU;
        if (cpu_req && io_req) begin
            grant = ~last_grant;
        end else if (io_req) begin
            grant = PORT_IO;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    // Fixed priority: I/O only wins when the CPU is not asking.
    always_comb begin
        grant = PORT_CPU;
        if (io_req && !cpu_req) begin
            grant = PORT_IO;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one 4096 x 16 memory between the CPU and the
// I/O loader, running every access as a fixed three-cycle transaction.
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie breaking; default is
// fixed CPU priority).
//
// Handshake: a requester raises req with we/addr/wdata stable and holds it
// until ack. Requests are sampled only while IDLE; the grant happens on that
// edge, the memory is driven in ACCESS, and ack pulses for exactly one cycle
// in COMPLETE (read data valid on rdata in that same cycle). A req still high
// in the IDLE cycle after ack is taken as a new transaction.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_ack,
    output logic [DATA_W-1:0] io_rdata,
    output logic [ADDR_W-1:0] mem_adress,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_indata,
    input  logic [DATA_W-1:0] mem_outdata,
    output logic              busy,
    output logic [1:0]        fsm_state
);

    state_t            state;
    state_t            state_next;
    logic              start;
    logic              grant;
    logic              last_grant;
    logic              win_port;
    logic              win_we;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    assign start      = (state == IDLE) && (cpu_req || io_req);
    assign mem_adress = addr_q;
    assign mem_indata = wdata_q;
    assign fsm_state  = state;

    mem_arb_picker u_picker (
        .cpu_req    (cpu_req),
        .io_req     (io_req),
        .last_grant (last_grant),
        .grant      (grant)
    );

`ifdef MEM_ARB_RR_EN
    // Remember who won the last grant; reset favours the CPU on the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_IO;
        end else if (start) begin
            last_grant <= grant;
        end
    end
`else
    assign last_grant = PORT_IO;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, memory strobes, acks and busy. Reads are the idle strobe so
    // read and write can never be active together.
    always_comb begin
        state_next = state;
        mem_read   = 1'b1;
        mem_write  = 1'b0;
        cpu_ack    = 1'b0;
        io_ack     = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (cpu_req || io_req) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                state_next = COMPLETE;
                if (win_we) begin
                    mem_read  = 1'b0;
                    mem_write = 1'b1;
                end
            end
            COMPLETE: begin
                state_next = IDLE;
                cpu_ack    = (win_port == PORT_CPU);
                io_ack     = (win_port == PORT_IO);
            end
            default: begin
                state_next = IDLE;
                busy       = 1'b0;
            end
        endcase
    end

    // Latch the winner's transaction on the grant edge. The address and write
    // data registers double as the memory outputs, so they hold between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_port <= PORT_CPU;
            win_we   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (start) begin
            win_port <= grant;
            if (grant == PORT_IO) begin
                win_we <= io_we;
                addr_q <= io_addr;
                if (io_we) begin
                    wdata_q <= io_wdata;
                end
            end else begin
                win_we <= cpu_we;
                addr_q <= cpu_addr;
                if (cpu_we) begin
                    wdata_q <= cpu_wdata;
                end
            end
        end
    end

    // Capture read data at the end of ACCESS into the winner's rdata only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata <= '0;
            io_rdata  <= '0;
        end else if (state == ACCESS && !win_we) begin
            if (win_port == PORT_CPU) begin
                cpu_rdata <= mem_outdata;
            end else begin
                io_rdata <= mem_outdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transactions, a transaction-level model
// checked every cycle, and hand-computed expectations for each scenario.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          io_req = 1'b0, io_we = 1'b0;
  logic [AW-1:0] io_addr = '0;
  logic [DW-1:0] io_wdata = '0;
  logic          cpu_ack, io_ack, mem_read, mem_write, busy;
  logic [DW-1:0] cpu_rdata, io_rdata, mem_indata, mem_outdata;
  logic [AW-1:0] mem_adress;
  logic [1:0]    fsm_state;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata),
    .mem_adress(mem_adress), .mem_read(mem_read), .mem_write(mem_write),
    .mem_indata(mem_indata), .mem_outdata(mem_outdata),
    .busy(busy), .fsm_state(fsm_state)
  );

  // Physical memory seen by the DUT.
  logic [DW-1:0] phys [4096];
  assign mem_outdata = phys[mem_adress];
  always @(posedge clk) begin
    if (!rst_n) phys[12'h123] <= 16'hBEEF;
    else if (mem_write) phys[mem_adress] <= mem_indata;
  end

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int io_ack_cnt = 0;
  int cpu_ack_cnt = 0;
  int wr_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A grant at the end of IDLE cycle g means: memory access in cycle g+1,
  // ack in g+2, free again in g+3.
  logic [DW-1:0] ref_mem [4096];
  int            cyc, g_cyc, m_port, m_last;
  bit            m_act, m_we;
  logic [AW-1:0] m_addr, m_madr;
  logic [DW-1:0] m_wdata, m_mind;
  logic [DW-1:0] m_rd [2];

  always @(posedge clk or negedge rst_n) begin : model
    int w;
    if (!rst_n) begin
      m_act = 1'b0; m_last = 1; m_port = 0; m_we = 1'b0;
      m_rd[0] = '0; m_rd[1] = '0; m_madr = '0; m_mind = '0;
      m_addr = '0; m_wdata = '0;
      cyc = 0; g_cyc = 0;
      ref_mem[12'h123] = 16'hBEEF;
    end else begin
      if (m_act) begin
        if (cyc == g_cyc + 1) begin
          if (m_we) ref_mem[m_addr] = m_wdata;
          else m_rd[m_port] = ref_mem[m_addr];
        end
        if (cyc == g_cyc + 2) m_act = 1'b0;
      end else if (cpu_req || io_req) begin
        if (cpu_req && io_req) begin
`ifdef MEM_ARB_RR_EN
          w = 1 - m_last;
`else
          w = 0;
`endif
        end else begin
          w = cpu_req ? 0 : 1;
        end
        m_last = w; m_port = w; m_act = 1'b1; g_cyc = cyc;
        if (w == 0) begin m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata; end
        else begin m_we = io_we; m_addr = io_addr; m_wdata = io_wdata; end
        m_madr = m_addr;
        if (m_we) m_mind = m_wdata;
      end
      cyc++;
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin : compare
    int ph;
    bit acc, cmpl;
    state_t es;
    if (cmp_en) begin
      ph   = m_act ? (cyc - g_cyc) : 0;
      acc  = m_act && (ph == 1);
      cmpl = m_act && (ph == 2);
      es   = !m_act ? IDLE : (acc ? ACCESS : COMPLETE);
      chk("fsm_state", fsm_state, es);
      chk("busy", busy, m_act);
      chk("mem_write", mem_write, acc && m_we);
      chk("mem_read", mem_read, !(acc && m_we));
      chk("rw_exclusive", mem_read & mem_write, 0);
      chk("mem_adress", mem_adress, m_madr);
      chk("mem_indata", mem_indata, m_mind);
      chk("cpu_ack", cpu_ack, cmpl && (m_port == 0));
      chk("io_ack", io_ack, cmpl && (m_port == 1));
      chk("cpu_rdata", cpu_rdata, m_rd[0]);
      chk("io_rdata", io_rdata, m_rd[1]);
    end
    if (io_ack) io_ack_cnt++;
    if (cpu_ack) cpu_ack_cnt++;
    if (mem_write) wr_cycles++;
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after a rising edge with req low.
  task automatic do_access(input bit port, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, output int lat, output logic [DW-1:0] rd);
    if (!port) begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
    else begin io_req = 1'b1; io_we = we; io_addr = addr; io_wdata = wd; end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(port ? io_ack : cpu_ack) && lat < 20);
    if (!(port ? io_ack : cpu_ack)) begin
      checks++; errors++;
      $display("FAIL ack_timeout actual=no ack required=ack within 20 cycles (port %0d)", port);
    end
    rd = port ? io_rdata : cpu_rdata;
    @(posedge clk); #1;
    if (!port) cpu_req = 1'b0; else io_req = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int lat, n0, w0;
    logic [DW-1:0] rd;
    int seq_q[$];
    int exp_seq[4];

    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values.
    @(negedge clk);
    chk("rst_fsm_state", fsm_state, IDLE);
    chk("rst_busy", busy, 0);
    chk("rst_mem_read", mem_read, 1);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_adress", mem_adress, 0);
    chk("rst_mem_indata", mem_indata, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_io_rdata", io_rdata, 0);
    @(posedge clk); #1;

    // CPU read of a preloaded word.
    n0 = io_ack_cnt;
    do_access(1'b0, 1'b0, 12'h123, 16'h0, lat, rd);
    chk("t1_latency", lat, 3);
    chk("t1_cpu_rdata", rd, 16'hBEEF);
    chk("t1_no_io_ack", io_ack_cnt - n0, 0);

    // I/O writes the top address, CPU reads it back.
    @(posedge clk); #1;
    w0 = wr_cycles;
    do_access(1'b1, 1'b1, 12'hFFF, 16'hA5A5, lat, rd);
    chk("t2_io_latency", lat, 3);
    chk("t2_write_cycles", wr_cycles - w0, 1);
    do_access(1'b0, 1'b0, 12'hFFF, 16'h0, lat, rd);
    chk("t2_cpu_rdata", rd, 16'hA5A5);

    // Write followed immediately by a read of the same word.
    do_access(1'b0, 1'b1, 12'h010, 16'h0001, lat, rd);
    chk("t3_rdata_after_write", rd, 16'hA5A5);
    do_access(1'b0, 1'b0, 12'h010, 16'h0, lat, rd);
    chk("t3_read_latency", lat, 3);
    chk("t3_rdata_after_read", rd, 16'h0001);

    // Reset asserted during a write ACCESS.
    @(posedge clk); #1;
    n0 = cpu_ack_cnt;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h777; cpu_wdata = 16'h1234;
    @(negedge clk);
    @(negedge clk);
    chk("t4_write_in_access", mem_write, 1);
    #1 rst_n = 1'b0; cpu_req = 1'b0;
    #1;
    chk("t4_mem_write", mem_write, 0);
    chk("t4_mem_read", mem_read, 1);
    chk("t4_busy", busy, 0);
    chk("t4_fsm_state", fsm_state, IDLE);
    chk("t4_mem_adress", mem_adress, 0);
    chk("t4_mem_indata", mem_indata, 0);
    chk("t4_cpu_ack", cpu_ack, 0);
    chk("t4_cpu_rdata", cpu_rdata, 0);
    chk("t4_io_rdata", io_rdata, 0);

    // Both ports request continuously from reset.
    cpu_we = 1'b0; cpu_addr = 12'h123; cpu_req = 1'b1;
    io_we = 1'b0; io_addr = 12'hFFF; io_req = 1'b1;
    repeat (2) @(posedge clk);
    chk("t4_no_ack_in_reset", cpu_ack_cnt - n0, 0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (cpu_ack) seq_q.push_back(0);
      if (io_ack) seq_q.push_back(1);
    end
`ifdef MEM_ARB_RR_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    chk("t5_ack_count", seq_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_winner_%0d", i), (i < seq_q.size()) ? seq_q[i] : 9, exp_seq[i]);
    end
    // Dropping req mid-transaction still yields its ack (checked by the model).
    @(posedge clk); #1;
    cpu_req = 1'b0; io_req = 1'b0;
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
